pc_gen: RTL
===========

Name: pc_gen

Overview:
Parametrised fetch-address generator; successor to the single-cycle PC register. Drives the instruction-fetch address with a valid/ready handshake to instruction memory. Accepts control-flow redirects computed relative to the resolving instruction's PC, plus trap, mret and halt/resume control. Detects misaligned targets and parks in an error state. Sits between the execute/branch unit, the CSR/trap logic and the instruction memory port.

Parameters:
XLEN, 32, address/data width in bits (32 or 64)
RESET_VECTOR, 0, PC value loaded on reset (XLEN bits, must be 4-byte aligned)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
fetch_ready  in  1  imem accepts current pc_cnt this cycle
pc_src  in  2  00 sequential, 01 base_pc+offset (JAL/branch taken), 10 (rs1+offset)&~1 (JALR), 11 reserved (treated as 00)
base_pc  in  XLEN  PC of the instruction resolving the jump
rs1  in  XLEN  JALR base register value
offset  in  XLEN  sign-extended immediate
trap  in  1  take trap this cycle
trap_vec  in  XLEN  trap target (mtvec)
mret  in  1  return from trap
epc  in  XLEN  mret target (mepc)
halt_req  in  1  request halt
resume  in  1  leave HALT
pc_cnt  out  XLEN  current fetch address
pc_valid  out  1  pc_cnt is a live fetch request
misalign_err  out  1  misaligned target detected, level while in ERR
bad_target  out  XLEN  offending target (for mtval)

Behaviour:
- Reset (async, any state, mid-operation included): pc_cnt=RESET_VECTOR, pc_valid=0, misalign_err=0, bad_target=0, state=BOOT.
- States: BOOT, RUN, HALT, ERR. All arithmetic is XLEN-bit, modulo 2^XLEN; wrap-around is silent (0xFFFFFFFC+4 -> 0x0).
- BOOT: one cycle, pc_valid=0 -> RUN unconditionally; pc_cnt holds RESET_VECTOR. pc_valid=1 from the first RUN cycle.
- RUN, per-cycle priority: trap > mret > halt_req > redirect (pc_src 01/10) > sequential.
  - trap: pc_cnt<=trap_vec, stay RUN.
  - mret: pc_cnt<=epc.
  - halt_req: -> HALT, pc_cnt held, pc_valid=0 next cycle.
  - redirect: target computed; if target[1:0]!=00 -> ERR, bad_target<=target, misalign_err<=1, pc_cnt held. Otherwise pc_cnt<=target. Applies regardless of fetch_ready; an unaccepted request is replaced.
  - sequential: pc_cnt<=pc_cnt+4 only when fetch_ready=1, else hold. pc_cnt stays stable while pc_valid=1 and fetch_ready=0.
- trap_vec and epc are not alignment-checked; low two bits are forced to 00.
- HALT: pc_valid=0. trap -> RUN at trap_vec. Otherwise resume -> RUN with pc_cnt unchanged.
- ERR: pc_valid=0, misalign_err=1. Exit only via trap: -> RUN at trap_vec, misalign_err<=0. bad_target holds until the next error or reset.
- Next-cycle latency for every update; no combinational path from inputs to pc_cnt.

Optional Feature:
PC_COMPRESSED_EN: adds input is_compressed (1 bit). Sequential step becomes +2 when is_compressed=1, else +4. Misalign check uses only target[0], so JALR can never fault. trap_vec/epc force only bit0 to 0. Without the macro: fixed +4 step, 4-byte alignment checks as above, no is_compressed port.

Decomposition:
- Package pc_gen_pkg: state enum (BOOT/RUN/HALT/ERR), pc_src encodings (PC_SEQ, PC_REL, PC_JALR), IALIGN_MASK constants for the 16- and 32-bit cases.
- Sub-module pc_target_calc (combinational): from pc_src, base_pc, rs1, offset produces target and misaligned. Instantiated once.

Test Plan:
- Reset with RESET_VECTOR=0x80000000 -> pc_cnt=0x80000000, pc_valid 0 for one cycle then 1; fetch_ready=1 for 3 cycles -> 0x80000004, 0x80000008, 0x8000000C.
- fetch_ready=0 for 2 cycles in RUN -> pc_cnt held and pc_valid=1. JALR with rs1=0x1001, offset=3 -> pc_cnt=0x1004 next cycle.
- Branch base_pc=0x100, offset=0x6 -> ERR, misalign_err=1, bad_target=0x106, pc_valid=0. Then trap with trap_vec=0x200 -> RUN, pc_cnt=0x200, misalign_err=0.
- Same cycle: trap (trap_vec=0x300), mret, halt_req and pc_src=01 all asserted -> pc_cnt=0x300, state RUN.
- pc_cnt=0xFFFFFFFC with fetch_ready=1 -> 0x00000000. halt_req -> pc_valid=0 and pc held through 5 cycles; resume -> same pc, pc_valid=1.
- rstn low mid-redirect while in HALT -> immediate RESET_VECTOR, pc_valid=0, BOOT sequence repeats.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// ---------------------------------------------------------------------------
// pc_gen_pkg
// Shared types and constants for the fetch-address generator.
//   - pc_state_e  : generator state (BOOT / RUN / HALT / ERR)
//   - PC_SEQ/PC_REL/PC_JALR : pc_src encodings (2'b11 is reserved, acts as SEQ)
//   - IALIGN_MASK_32 / IALIGN_MASK_16 : low target bits that must be zero
//   - IALIGN_MASK : the mask in effect for this build
// Build option: define PC_COMPRESSED_EN to allow 16-bit instruction alignment.
// ---------------------------------------------------------------------------
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_ERR  = 2'd3
  } pc_state_e;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_REL  = 2'b01;
  localparam logic [1:0] PC_JALR = 2'b10;

  localparam logic [1:0] IALIGN_MASK_32 = 2'b11;
  localparam logic [1:0] IALIGN_MASK_16 = 2'b01;

`ifdef PC_COMPRESSED_EN
  localparam logic [1:0] IALIGN_MASK = IALIGN_MASK_16;
`else
  localparam logic [1:0] IALIGN_MASK = IALIGN_MASK_32;
`endif

endpackage

// File: rtl/pc_target_calc.sv
// ---------------------------------------------------------------------------
// pc_target_calc
// Combinational redirect target computation.
// Ports:
//   pc_src     in  2     redirect kind (PC_REL, PC_JALR; others = no redirect)
//   base_pc    in  XLEN  PC of the resolving instruction
//   rs1        in  XLEN  JALR base register
//   offset     in  XLEN  sign-extended immediate
//   target     out XLEN  computed target (0 when no redirect)
//   misaligned out 1     target violates instruction alignment
// Build option: PC_COMPRESSED_EN (via pc_gen_pkg::IALIGN_MASK) relaxes the
// alignment check to bit 0 only.
// ---------------------------------------------------------------------------
module pc_target_calc
  import pc_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] base_pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] offset,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] rel_sum;
  logic [XLEN-1:0] jalr_sum;

  // Plain modulo-2^XLEN adds; the offset is already sign-extended so
  // two's-complement wrap gives the correct backward targets.
  assign rel_sum  = base_pc + offset;
  assign jalr_sum = rs1 + offset;

  always_comb begin
    target = '0;
    case (pc_src)
      PC_REL:  target = rel_sum;
      PC_JALR: target = {jalr_sum[XLEN-1:1], 1'b0};
      default: target = '0;
    endcase
  end

  assign misaligned = |(target[1:0] & IALIGN_MASK);

endmodule

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
// Fetch-address generator with valid/ready handshake to instruction memory.
// Handles sequential stepping, relative/JALR redirects, trap entry, mret,
// halt/resume and misaligned-target detection (parks in ERR until a trap).
// Ports:
//   clk           in  1     clock, rising edge
//   rstn          in  1     asynchronous active-low reset
//   fetch_ready   in  1     imem accepts pc_cnt this cycle
//   pc_src        in  2     00 seq, 01 base_pc+offset, 10 (rs1+offset)&~1, 11 seq
//   base_pc       in  XLEN  PC of the resolving instruction
//   rs1           in  XLEN  JALR base value
//   offset        in  XLEN  sign-extended immediate
//   trap          in  1     take trap this cycle
//   trap_vec      in  XLEN  trap target
//   mret          in  1     return from trap
//   epc           in  XLEN  mret target
//   halt_req      in  1     request halt
//   resume        in  1     leave HALT
//   is_compressed in  1     (PC_COMPRESSED_EN only) step by 2 instead of 4
//   pc_cnt        out XLEN  current fetch address
//   pc_valid      out 1     pc_cnt is a live fetch request
//   misalign_err  out 1     high while parked in ERR
//   bad_target    out XLEN  last offending target
// Build option: PC_COMPRESSED_EN adds is_compressed and 2-byte alignment.
// All outputs are registered; no input reaches pc_cnt combinationally.
// ---------------------------------------------------------------------------
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            fetch_ready,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] base_pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] offset,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            mret,
  input  logic [XLEN-1:0] epc,
  input  logic            halt_req,
  input  logic            resume,
`ifdef PC_COMPRESSED_EN
  input  logic            is_compressed,
`endif
  output logic [XLEN-1:0] pc_cnt,
  output logic            pc_valid,
  output logic            misalign_err,
  output logic [XLEN-1:0] bad_target
);

  localparam logic [XLEN-1:0] ALIGN_CLR = ~(XLEN'(IALIGN_MASK));

  pc_state_e       state;
  logic [XLEN-1:0] tgt;
  logic            tgt_mis;
  logic            redirect;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] epc_pc;
  logic [XLEN-1:0] seq_step;

  pc_target_calc #(
    .XLEN (XLEN)
  ) u_target (
    .pc_src     (pc_src),
    .base_pc    (base_pc),
    .rs1        (rs1),
    .offset     (offset),
    .target     (tgt),
    .misaligned (tgt_mis)
  );

  assign redirect = (pc_src == PC_REL) || (pc_src == PC_JALR);

  // Trap and return targets come from CSRs and are trusted; the low bits
  // are simply cleared instead of being checked.
  assign trap_pc = trap_vec & ALIGN_CLR;
  assign epc_pc  = epc & ALIGN_CLR;

`ifdef PC_COMPRESSED_EN
  assign seq_step = is_compressed ? XLEN'(2) : XLEN'(4);
`else
  assign seq_step = XLEN'(4);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_BOOT;
      pc_cnt       <= RESET_VECTOR;
      pc_valid     <= 1'b0;
      misalign_err <= 1'b0;
      bad_target   <= '0;
    end else begin
      case (state)
        // BOOT: one idle cycle holding RESET_VECTOR before fetching starts
        ST_BOOT: begin
          state    <= ST_RUN;
          pc_valid <= 1'b1;
        end

        // RUN: trap > mret > halt_req > redirect > sequential
        ST_RUN: begin
          if (trap) begin
            pc_cnt <= trap_pc;
          end else if (mret) begin
            pc_cnt <= epc_pc;
          end else if (halt_req) begin
            state    <= ST_HALT;
            pc_valid <= 1'b0;
          end else if (redirect) begin
            // A redirect replaces any request imem has not yet accepted.
            if (tgt_mis) begin
              state        <= ST_ERR;
              pc_valid     <= 1'b0;
              misalign_err <= 1'b1;
              bad_target   <= tgt;
            end else begin
              pc_cnt <= tgt;
            end
          end else if (fetch_ready) begin
            pc_cnt <= pc_cnt + seq_step;
          end
        end

        // HALT: trap wins over resume; resume continues at the held PC
        ST_HALT: begin
          if (trap) begin
            state    <= ST_RUN;
            pc_cnt   <= trap_pc;
            pc_valid <= 1'b1;
          end else if (resume) begin
            state    <= ST_RUN;
            pc_valid <= 1'b1;
          end
        end

        // ERR: only a trap leaves; bad_target is kept for mtval
        ST_ERR: begin
          if (trap) begin
            state        <= ST_RUN;
            pc_cnt       <= trap_pc;
            pc_valid     <= 1'b1;
            misalign_err <= 1'b0;
          end
        end

        default: begin
          state    <= ST_BOOT;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
